rvvi_retire_scheduler: RTL
==========================

Name: rvvi_retire_scheduler

Overview:
- Serializes multi-hart, multi-retire RVVI trace traffic into one in-order instruction stream for the coverage sampler.
- Sits between the rvviTrace interface and the coverage sample call, so the sampler sees at most one retired instruction per clock.
- Each cycle, valid retire slots are buffered in a compacting FIFO and drained one per cycle under a ready/valid handshake.
- Buffer overflow is detected and counted.

Parameters:
- ILEN, 32, instruction width.
- XLEN, 64, PC width.
- NHART, 1, number of harts.
- RETIRE, 1, retire slots per hart per cycle.
- DEPTH, 16, FIFO entries. Power of 2; DEPTH >= NHART*RETIRE, else elaboration error.
- Derived: S = NHART*RETIRE; HW = max(1, clog2(NHART)); RW = max(1, clog2(RETIRE)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of FIFO, overflow flag and drop counter.
- in_valid  in  S  per-slot retire valid; slot index = hart*RETIRE + slot.
- in_insn  in  S*ILEN  per-slot instruction bits.
- in_pc  in  S*XLEN  per-slot pc_rdata.
- in_trap  in  S  per-slot trap flag.
- out_valid  out  1  head entry available.
- out_ready  in  1  sampler accepts head this cycle.
- out_hart  out  HW  hart of head entry.
- out_slot  out  RW  retire slot of head entry.
- out_insn  out  ILEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_trap  out  1  head trap flag.
- count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one retire group was dropped.
- drop_count  out  16  dropped instructions, saturating at 0xFFFF.

Behaviour:
- Reset (async, active-high): head, tail and count = 0; out_valid = 0; overflow = 0; drop_count = 0; out_hart, out_slot, out_insn, out_pc and out_trap = 0.
- Ordering:
  - Within a cycle, valid slots are enqueued in ascending index order (hart 0 slot 0 first).
  - Slots with in_valid = 0 are skipped. Entries are compacted, never holes.
  - Across cycles, order is strict FIFO.
- Enqueue:
  - n = popcount(in_valid).
  - deq = out_valid & out_ready.
  - free = DEPTH - count + deq. A dequeue in the same cycle frees its slot for that cycle's enqueue.
  - If n <= free: all n entries are written at tail..tail+n-1 (mod DEPTH) and tail advances by n.
  - If n > free: all-or-nothing. No entry of that cycle is written; overflow is set; drop_count += n, saturating.
- Dequeue:
  - Show-ahead FIFO: out_* are driven from the head entry.
  - out_valid = (count != 0).
  - On deq, head advances by 1 (mod DEPTH).
  - out_ready is ignored while out_valid = 0.
  - Outputs are stable while out_valid = 1 and out_ready = 0.
- Latency: an instruction retired at edge N with an empty FIFO appears on out_* after edge N; it can be accepted at edge N+1. There is no combinational in->out bypass.
- count(next) = count + (accepted n) - deq. Valid range is 0..DEPTH.
- Pointer wrap: head and tail wrap modulo DEPTH. Full vs empty is decided by count, not pointer equality.
- clear has priority over enqueue and dequeue in the same cycle: FIFO emptied, overflow = 0, drop_count = 0, and that cycle's inputs are discarded.
- Reset asserted mid-stream: buffered entries are lost; no output glitch beyond out_valid falling immediately.
- drop_count holds at 0xFFFF once saturated; overflow stays 1 until reset or clear.

Test Plan:
- NHART=1, RETIRE=1: retire insn 0x00500093 at pc 0x80000000, out_ready=1 -> out_valid high one cycle later with the same insn/pc, hart 0, slot 0; count returns to 0.
- NHART=2, RETIRE=2, in_valid=4'b1011 in one cycle -> outputs appear in slot order idx0, idx1, idx3 (hart0/s0, hart0/s1, hart1/s1) on three consecutive cycles; idx2 never appears.
- DEPTH=4, out_ready=0: a 4-valid group followed next cycle by a 1-valid group -> count=4, overflow=1, drop_count=1; after draining, exactly the first 4 entries are output.
- DEPTH=4, count=4, out_ready=1 while 1 new valid arrives -> accepted (free=1); count stays 4; overflow stays 0.
- Stream 40 instructions through DEPTH=16 with out_ready toggling 1,0,1,0 -> all 40 output in order across pointer wraps; out_* stable during stalls; no drops.
- With overflow=1 and drop_count=5: assert clear together with a valid input -> count=0, overflow=0, drop_count=0, that cycle's input discarded. Separately, assert reset mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/rvvi_retire_scheduler.sv
// Serializes multi-hart, multi-slot RVVI retire traffic into a single in-order
// stream through a compacting show-ahead FIFO with all-or-nothing group overflow.
module rvvi_retire_scheduler #(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int DEPTH  = 16,
    localparam int S     = NHART * RETIRE,
    localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1,
    localparam int RW    = (RETIRE > 1) ? $clog2(RETIRE) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [S-1:0]        in_valid,
    input  logic [S*ILEN-1:0]   in_insn,
    input  logic [S*XLEN-1:0]   in_pc,
    input  logic [S-1:0]        in_trap,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HW-1:0]       out_hart,
    output logic [RW-1:0]       out_slot,
    output logic [ILEN-1:0]     out_insn,
    output logic [XLEN-1:0]     out_pc,
    output logic                out_trap,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic [15:0]         drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = HW + RW + 1 + XLEN + ILEN;
    localparam int FW = CW + 1;
    localparam logic [CW-1:0] MASK = CW'(DEPTH - 1);

    if (DEPTH < NHART * RETIRE || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rvvi_retire_scheduler: DEPTH must be a power of 2 and >= NHART*RETIRE");
    end

    logic [EW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  head_r;
    logic [AW-1:0]  tail_r;
    logic [CW-1:0]  count_r;
    logic           overflow_r;
    logic [15:0]    drop_count_r;

    logic [CW-1:0]  n_s;
    logic [FW-1:0]  free_s;
    logic           deq_s;
    logic           accept_s;
    logic [16:0]    drop_sum_s;
    logic [EW-1:0]  entry_s [S];
    logic [AW-1:0]  widx_s [S];

    // Compaction: each valid slot lands at tail plus the number of valid slots below it.
    always_comb begin
        n_s = '0;
        for (int i = 0; i < S; i++) begin
            entry_s[i] = {HW'(i / RETIRE), RW'(i % RETIRE), in_trap[i],
                          in_pc[i*XLEN +: XLEN], in_insn[i*ILEN +: ILEN]};
            widx_s[i]  = AW'((CW'(tail_r) + n_s) & MASK);
            n_s        = n_s + CW'(in_valid[i]);
        end
        deq_s      = (count_r != CW'(0)) & out_ready;
        free_s     = FW'(DEPTH) - {1'b0, count_r} + FW'(deq_s);
        accept_s   = ({1'b0, n_s} <= free_s);
        drop_sum_s = 17'(drop_count_r) + 17'(n_s);
    end

    // FIFO storage, pointers, occupancy and overflow accounting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            if (deq_s) begin
                head_r <= AW'((CW'(head_r) + CW'(1)) & MASK);
            end
            if (accept_s) begin
                for (int i = 0; i < S; i++) begin
                    if (in_valid[i]) begin
                        mem_r[widx_s[i]] <= entry_s[i];
                    end
                end
                tail_r <= AW'((CW'(tail_r) + n_s) & MASK);
            end else begin
                overflow_r   <= 1'b1;
                drop_count_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            end
            count_r <= count_r + (accept_s ? n_s : CW'(0)) - CW'(deq_s);
        end
    end

    // Show-ahead read straight from the head register entry; no input bypass.
    assign {out_hart, out_slot, out_trap, out_pc, out_insn} = mem_r[head_r];
    assign out_valid  = (count_r != CW'(0));
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule
